cache_wb_sa: RTL and testbench
==============================

# cache_wb_sa

Parametrised write-back, write-allocate, direct-mapped data/instruction cache sitting between the multi-cycle CPU datapath and the block-wide memory model. Line count and words per line are parameters. A single FSM sequences dirty-victim write-back and line fill. Separate read/write data buses replace the shared tri-state bus, and hit/access statistics counters are optional.

## Interface
- `ADDR_W`, default 16: word address width.
- `WORD_W`, default 16: datapath word width.
- `LINES`, default 4: number of lines; power of two, ≥2.
- `WORDS`, default 4: words per line; power of two, ≥2.
- Derived widths:
  - `IDX_W` = log2(`LINES`).
  - `OFF_W` = log2(`WORDS`).
  - `TAG_W` = `ADDR_W`−`IDX_W`−`OFF_W`.
  - `LINE_W` = `WORDS`·`WORD_W`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `readC`  in  1  read request; held until `readyC`.
- `writeC`  in  1  write request; held until `readyC`.
- `address`  in  `ADDR_W`  word address; stable while the request is held.
- `wdata`  in  `WORD_W`  write data.
- `rdata`  out  `WORD_W`  read data; valid when `readyC`, otherwise 0.
- `readyC`  out  1  access completes this cycle.
- `mem_addr`  out  `ADDR_W`  line-aligned memory address; offset bits are 0.
- `mem_wdata`  out  `LINE_W`  victim line during write-back.
- `mem_rdata`  in  `LINE_W`  fill data; sampled when `readyM`=1.
- `readM`  out  1  line read request.
- `writeM`  out  1  line write request.
- `readyM`  in  1  memory completes the current request.
- `num_access`  out  16  completed accesses.
- `num_hit`  out  16  completed accesses that required no fill.

## Operation
- Address split: `tag` = `address`[ADDR_W−1 : IDX_W+OFF_W], `idx` = next `IDX_W` bits, `off` = low `OFF_W` bits.
- `hit` = `valid[idx]` && `tag_bank[idx]` == `tag`. `readyC` = (`readC`|`writeC`) && `hit` && state==IDLE.
- If `readC` and `writeC` are both high, the access is a write.
- FSM states: IDLE, WB, FILL.
- IDLE:
  - Read hit: `rdata` = word `off` of the line, combinationally.
  - Write hit: at the edge, word `off` ← `wdata` and `dirty[idx]` ← 1, unconditionally.
  - Miss with `valid`&&`dirty` victim: go to WB. Other miss: go to FILL.
- WB:
  - `writeM`=1, `mem_addr`={`tag_bank[idx]`,`idx`,0}, `mem_wdata`=`data_bank[idx]`.
  - On an edge with `readyM`: `dirty[idx]`←0, then go to FILL.
- FILL:
  - `readM`=1, `mem_addr`={`tag`,`idx`,0}.
  - On an edge with `readyM`: line ← `mem_rdata`, tag ← `tag`, `valid`←1, `dirty`←0, then go to IDLE.
  - The access then hits in IDLE (write-allocate: the write lands on that hit).
- `readM` and `writeM` are registered, never both 1, and 0 in IDLE.
- `readyM` is ignored in IDLE.
- Reset mid-operation: all `valid` and `dirty` cleared, FSM to IDLE, `readM`/`writeM` low. An in-flight write-back is abandoned.

## Timing
- Reset values: `readyC`=0, `rdata`=0, `readM`=0, `writeM`=0, `mem_addr`=0, `mem_wdata`=0, counters=0. Tag and data arrays are don't-care.
- Hit latency is 0 cycles: `readyC` is high in the request cycle.
- Clean miss: `readM` rises 1 cycle after the request. If `readyM` arrives N cycles after `readM` rises, `readyC` is high at request cycle + N + 2.
- Dirty miss: adds the write-back handshake, plus 1 cycle from WB to FILL.
- `readyM` may be high in the first cycle of a request. The minimum handshake is 1 cycle per state.

## Configuration
- Macro `CACHE_WB_STATS_EN`.
- Defined:
  - `num_access` increments on every edge with `readyC` high.
  - `num_hit` increments on the same edge only if that access never left IDLE. A registered `missed` flag is set on IDLE→WB/FILL and cleared on `readyC`.
  - Both counters saturate at 16'hFFFF.
- Undefined: no counter logic is built; both outputs are tied to 0.

## Test plan
- Reset, then read 16'h0010 with a 2-cycle `readyM` and `mem_rdata`=64'h4444_3333_2222_1111:
  - `readM` pulses, with no `writeM`.
  - `readyC` is high with `rdata`=16'h1111.
  - A following read of 16'h0013 hits at once with 16'h4444.
- Write 16'hBEEF to 16'h0011 (line resident), then read 16'h0031 (same index, new tag):
  - WB first: `mem_addr`=16'h0010, `mem_wdata` word 1=16'hBEEF.
  - Then FILL: `mem_addr`=16'h0030.
- Write miss to clean 16'h0050:
  - Goes to FILL only, then the write lands.
  - Read-back returns `wdata`; the line is dirty.
- Assert `reset_n` low during WB while `writeM`=1:
  - `writeM` drops asynchronously.
  - The next read of the old address misses and shows no write-back.
- With `CACHE_WB_STATS_EN`, run 3 misses followed by 5 hits: `num_access`=8, `num_hit`=5. Without it, both read 0.
- `readC` and `writeC` both high on a hit: treated as a write, `dirty` set, `readyC` high in that cycle.

Source files
------------

// File: rtl/cache_wb_sa.sv
// Write-back, write-allocate, direct-mapped cache with an IDLE/WB/FILL sequencer.
// Optional hit/access statistics counters are built when CACHE_WB_STATS_EN is defined.
module cache_wb_sa #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int LINES  = 4,
  parameter int WORDS  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      readC,
  input  logic                      writeC,
  input  logic [ADDR_W-1:0]         address,
  input  logic [WORD_W-1:0]         wdata,
  output logic [WORD_W-1:0]         rdata,
  output logic                      readyC,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WORDS*WORD_W-1:0]   mem_wdata,
  input  logic [WORDS*WORD_W-1:0]   mem_rdata,
  output logic                      readM,
  output logic                      writeM,
  input  logic                      readyM,
  output logic [15:0]               num_access,
  output logic [15:0]               num_hit,
  output logic [1:0]                dbg_state
);
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = WORDS * WORD_W;
  localparam int BASE_W = $clog2(LINE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [LINE_W-1:0]   r_data [LINES];
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic                r_read_m;
  logic                r_write_m;

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [OFF_W-1:0]    w_off;
  logic [BASE_W-1:0]   w_base;
  logic                w_req;
  logic                w_hit;
  logic                w_ready;
  logic                w_wr_hit;
  logic                w_fill_done;
  logic                w_wb_done;

  assign w_tag       = address[ADDR_W-1 -: TAG_W];
  assign w_idx       = address[OFF_W +: IDX_W];
  assign w_off       = address[OFF_W-1:0];
  assign w_base      = BASE_W'(w_off) * BASE_W'(WORD_W);
  assign w_req       = readC | writeC;
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ready     = w_req && w_hit && (r_state == S_IDLE);
  // writeC wins when both requests are raised together
  assign w_wr_hit    = w_ready && writeC;
  assign w_fill_done = (r_state == S_FILL) && readyM;
  assign w_wb_done   = (r_state == S_WB) && readyM;

  assign readyC    = w_ready;
  assign rdata     = w_ready ? r_data[w_idx][w_base +: WORD_W] : '0;
  assign readM     = r_read_m;
  assign writeM    = r_write_m;
  assign dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req && !w_hit) w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FILL;
      S_WB:   if (readyM) w_next = S_FILL;
      S_FILL: if (readyM) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_WB: begin
        mem_addr  = {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
        mem_wdata = r_data[w_idx];
      end
      S_FILL: mem_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
      default: ;
    endcase
  end

  // Memory strobes are registered from the next state so they track WB/FILL exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_read_m  <= 1'b0;
      r_write_m <= 1'b0;
      r_valid   <= '0;
      r_dirty   <= '0;
    end else begin
      r_state   <= w_next;
      r_read_m  <= (w_next == S_FILL);
      r_write_m <= (w_next == S_WB);
      if (w_fill_done) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_wb_done) begin
        r_dirty[w_idx] <= 1'b0;
      end else if (w_wr_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[w_idx] <= mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][w_base +: WORD_W] <= wdata;
    end
  end

`ifdef CACHE_WB_STATS_EN
  logic [15:0] r_num_access;
  logic [15:0] r_num_hit;
  logic        r_missed;

  // r_missed marks an access that had to leave IDLE before completing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num_access <= '0;
      r_num_hit    <= '0;
      r_missed     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_next != S_IDLE)) r_missed <= 1'b1;
      else if (w_ready)                              r_missed <= 1'b0;
      if (w_ready) begin
        if (r_num_access != 16'hFFFF)           r_num_access <= r_num_access + 16'd1;
        if (!r_missed && r_num_hit != 16'hFFFF) r_num_hit    <= r_num_hit + 16'd1;
      end
    end
  end

  assign num_access = r_num_access;
  assign num_hit    = r_num_hit;
`else
  assign num_access = 16'd0;
  assign num_hit    = 16'd0;
`endif

endmodule

// File: tb/tb_cache_wb_sa.sv
// Directed plus randomized checks of cache_wb_sa against a line-level cache/memory model.
module tb_cache_wb_sa;
  logic        clk;
  logic        reset_n;
  logic        readC;
  logic        writeC;
  logic [15:0] address;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        readyC;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        readM;
  logic        writeM;
  logic        readyM;
  logic [15:0] num_access;
  logic [15:0] num_hit;
  logic [1:0]  dbg_state;

  cache_wb_sa #(.ADDR_W(16), .WORD_W(16), .LINES(4), .WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .readC(readC), .writeC(writeC),
    .address(address), .wdata(wdata), .rdata(rdata), .readyC(readyC),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .readM(readM), .writeM(writeM), .readyM(readyM),
    .num_access(num_access), .num_hit(num_hit), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one entry per cache line plus a sparse backing memory of lines.
  bit          m_valid [4];
  bit          m_dirty [4];
  logic [11:0] m_tag   [4];
  logic [63:0] m_data  [4];
  logic [63:0] mem_m   [logic [13:0]];
  int          exp_access;
  int          exp_hits;

  int          n_checks;
  int          n_fail;
  logic [15:0] last_rd;
  logic [15:0] last_wb_addr;
  logic [63:0] last_wb_data;
  bit          last_wb_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_line(input logic [13:0] la);
    if (!mem_m.exists(la)) mem_m[la] = {$urandom, $urandom};
    return mem_m[la];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_access = 0;
    exp_hits   = 0;
  endtask

  task automatic chk_counters(input string tag);
`ifdef CACHE_WB_STATS_EN
    chk({tag, "_num_access"}, num_access, 64'(exp_access));
    chk({tag, "_num_hit"}, num_hit, 64'(exp_hits));
`else
    chk({tag, "_num_access"}, num_access, 64'd0);
    chk({tag, "_num_hit"}, num_hit, 64'd0);
`endif
  endtask

  // One CPU access with a memory responder; abort_at >= 0 pulls reset during write-back.
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, input int wb_lat, input int fill_lat,
                        input int abort_at);
    logic [1:0]  idx;
    logic [11:0] tag;
    logic [1:0]  off;
    bit          exp_hit;
    bit          exp_wb;
    bit          done;
    bit          seen_wb;
    bit          seen_fill;
    int          cyc;
    int          wb_cnt;
    int          fill_cnt;
    int          exp_lat;
    logic [15:0] got_rd;
    idx = addr[3:2];
    tag = addr[15:4];
    off = addr[1:0];
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
    done = 0; seen_wb = 0; seen_fill = 0;
    cyc = 0; wb_cnt = 0; fill_cnt = 0;
    got_rd = '0;
    @(negedge clk);
    readC = rd; writeC = wr; address = addr; wdata = wd;
    while (!done && cyc < 200) begin
      #1;
      chk("strobe_exclusive", 64'(readM && writeM), 64'd0);
      if (readyC) begin
        done = 1;
        if (rd && !wr) got_rd = rdata;
      end else begin
        chk("rdata_zero_when_busy", rdata, 64'd0);
        if (writeM) begin
          if (wb_cnt == 0) begin
            chk("wb_mem_addr", mem_addr, {m_tag[idx], idx, 2'b00});
            chk("wb_mem_wdata", mem_wdata, m_data[idx]);
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
          end
          seen_wb = 1;
          if (wb_cnt == abort_at) begin
            reset_n = 1'b0;
            #1;
            chk("abort_writeM", writeM, 64'd0);
            chk("abort_readM", readM, 64'd0);
            chk("abort_mem_addr", mem_addr, 64'd0);
            chk("abort_readyC", readyC, 64'd0);
            readC = 0; writeC = 0; readyM = 0;
            model_reset();
            @(negedge clk);
            reset_n = 1'b1;
            last_wb_seen = seen_wb;
            return;
          end
          readyM = (wb_cnt == wb_lat);
          wb_cnt++;
        end else if (readM) begin
          if (fill_cnt == 0) chk("fill_mem_addr", mem_addr, {tag, idx, 2'b00});
          seen_fill = 1;
          readyM = (fill_cnt == fill_lat);
          mem_rdata = readyM ? mem_line({tag, idx}) : {$urandom, $urandom};
          fill_cnt++;
        end else begin
          readyM = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("access_completes", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    readC = 0; writeC = 0; readyM = 0;
    if (!done) return;
    exp_lat = exp_hit ? 0 : (exp_wb ? wb_lat + fill_lat + 3 : fill_lat + 2);
    chk("hit_expected", 64'(cyc == 0), 64'(exp_hit));
    chk("wb_expected", 64'(seen_wb), 64'(exp_wb));
    chk("fill_expected", 64'(seen_fill), 64'(!exp_hit));
    chk("latency", 64'(cyc), 64'(exp_lat));
    if (!exp_hit) begin
      if (exp_wb) mem_m[{m_tag[idx], idx}] = m_data[idx];
      m_data[idx]  = mem_line({tag, idx});
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_access++;
    if (exp_hit) exp_hits++;
    if (wr) begin
      m_data[idx][off*16 +: 16] = wd;
      m_dirty[idx] = 1'b1;
    end else begin
      chk("read_data", got_rd, m_data[idx][off*16 +: 16]);
    end
    last_rd = got_rd;
    last_wb_seen = seen_wb;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; readC = 1'b1; writeC = 1'b0; address = 16'h0010;
    wdata = '0; mem_rdata = '0; readyM = 1'b0;
    last_rd = '0; last_wb_addr = '0; last_wb_data = '0; last_wb_seen = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_readyC", readyC, 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_readM", readM, 64'd0);
    chk("reset_writeM", writeM, 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    chk("reset_mem_wdata", mem_wdata, 64'd0);
    chk("reset_num_access", num_access, 64'd0);
    chk("reset_num_hit", num_hit, 64'd0);
    readC = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Clean read miss with a known line, then hits; 3 misses + 5 hits for the counters.
    mem_m[14'h0004] = 64'h4444_3333_2222_1111;
    access(1, 0, 16'h0010, 16'h0, 0, 1, -1);
    chk("tp_first_read", last_rd, 64'h1111);
    chk("tp_first_no_wb", 64'(last_wb_seen), 64'd0);
    access(1, 0, 16'h0014, 16'h0, 0, 0, -1);
    access(1, 0, 16'h0018, 16'h0, 0, 2, -1);
    access(1, 0, 16'h0013, 16'h0, 0, 0, -1);
    chk("tp_hit_0013", last_rd, 64'h4444);
    access(1, 0, 16'h0011, 16'h0, 0, 0, -1);
    access(1, 0, 16'h0012, 16'h0, 0, 0, -1);
    access(1, 0, 16'h0015, 16'h0, 0, 0, -1);
    access(1, 0, 16'h0019, 16'h0, 0, 0, -1);
`ifdef CACHE_WB_STATS_EN
    chk("tp_stats_access", num_access, 64'd8);
    chk("tp_stats_hit", num_hit, 64'd5);
`else
    chk("tp_stats_access", num_access, 64'd0);
    chk("tp_stats_hit", num_hit, 64'd0);
`endif

    // Dirty victim: write-back of line 0x0010 precedes the fill of 0x0030.
    access(0, 1, 16'h0011, 16'hBEEF, 0, 0, -1);
    access(1, 0, 16'h0031, 16'h0, 2, 1, -1);
    chk("tp_wb_seen", 64'(last_wb_seen), 64'd1);
    chk("tp_wb_addr", last_wb_addr, 64'h0010);
    chk("tp_wb_word1", last_wb_data[31:16], 64'hBEEF);

    // Write miss to a clean victim: fill only, then the write lands.
    access(0, 1, 16'h0050, 16'hCAFE, 0, 1, -1);
    chk("tp_wmiss_no_wb", 64'(last_wb_seen), 64'd0);
    access(1, 0, 16'h0050, 16'h0, 0, 0, -1);
    chk("tp_wmiss_readback", last_rd, 64'hCAFE);

    // readC and writeC together on a hit act as a write.
    access(1, 1, 16'h0051, 16'h1234, 0, 0, -1);
    access(1, 0, 16'h0051, 16'h0, 0, 0, -1);
    chk("tp_both_readback", last_rd, 64'h1234);

    // Reset while the dirty line is being written back; the write-back is abandoned.
    access(1, 0, 16'h0090, 16'h0, 5, 0, 1);
    chk("tp_abort_wb_seen", 64'(last_wb_seen), 64'd1);
    chk_counters("post_abort");
    access(1, 0, 16'h0050, 16'h0, 0, 1, -1);
    chk("tp_after_abort_no_wb", 64'(last_wb_seen), 64'd0);

    // Randomized traffic over 8 tags so hits, clean and dirty misses all occur.
    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [15:0] a;
      logic [15:0] d;
      kind = $urandom_range(0, 3);
      a    = 16'($urandom_range(0, 127));
      d    = 16'($urandom);
      access(kind != 2, kind >= 2, a, d, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
    chk_counters("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
